// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned LAT_CNT_W = 4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker: a lone requester wins; on a tie the port that
// did not go last wins, unless fixed priority hands the tie to the core port.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       grant_c
);

  always_comb begin
    grant_c = PORT_CORE;
    if (req == 2'b10) begin
      grant_c = PORT_DBG;
    end else if ((req == 2'b11) && !fixed) begin
      grant_c = ~last;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core and debug ports onto one memory, one access at a time.
// Build option: define FIXED_PRIO_EN to give port 0 every tie.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Ack0,
  output logic [DATA_W-1:0] RData0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData1,
  output logic              MemEn,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy,
  output logic              Owner
);

`ifdef FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 rr_last_q, rr_last_d;
  logic                 grant;

  logic                 ack0_d, ack1_d, mem_en_d, mem_we_d, busy_d, owner_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d, rdata0_d, rdata1_d;

  arb_rr_pick u_pick (
    .req     ({Req1, Req0}),
    .last    (rr_last_q),
    .fixed   (FIXED_PRIO),
    .grant_c (grant)
  );

  // State and every output are registered from the next-state values below.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= PORT_DBG;
      Ack0      <= 1'b0;
      Ack1      <= 1'b0;
      MemEn     <= 1'b0;
      MemWE     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      RData0    <= '0;
      RData1    <= '0;
      Busy      <= 1'b0;
      Owner     <= PORT_CORE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      Ack0      <= ack0_d;
      Ack1      <= ack1_d;
      MemEn     <= mem_en_d;
      MemWE     <= mem_we_d;
      MemAddr   <= addr_d;
      MemWData  <= wdata_d;
      RData0    <= rdata0_d;
      RData1    <= rdata1_d;
      Busy      <= busy_d;
      Owner     <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    owner_d   = Owner;
    addr_d    = MemAddr;
    wdata_d   = MemWData;
    rdata0_d  = RData0;
    rdata1_d  = RData1;
    mem_en_d  = 1'b0;
    mem_we_d  = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          owner_d  = grant;
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (grant == PORT_DBG) begin
            addr_d   = Addr1;
            wdata_d  = WData1;
            mem_we_d = We1;
          end else begin
            addr_d   = Addr0;
            wdata_d  = WData0;
            mem_we_d = We0;
          end
        end
      end
      // MemWE still holds the latched direction during the strobe cycle.
      ISSUE: begin
        if (MemWE) begin
          ack0_d  = (Owner == PORT_CORE);
          ack1_d  = (Owner == PORT_DBG);
          state_d = DONE;
        end else begin
          cnt_d   = LAT_CNT_W'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_CNT_W'(1)) begin
          if (Owner == PORT_DBG) begin
            rdata1_d = MemRData;
          end else begin
            rdata0_d = MemRData;
          end
          ack0_d  = (Owner == PORT_CORE);
          ack1_d  = (Owner == PORT_DBG);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      DONE: begin
        rr_last_d = Owner;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with a 3-cycle memory, one with a 1-cycle memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk, rst;
  logic          req0, req1, we0, we1, ack0, ack1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy, owner;

  logic          b_req0, b_req1, b_we0, b_we1, b_ack0, b_ack1;
  logic [AW-1:0] b_addr0, b_addr1, b_mem_addr;
  logic [DW-1:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
  logic          b_mem_en, b_mem_we, b_busy, b_owner;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_a (
    .CLK(clk), .RST(rst),
    .Req0(req0), .We0(we0), .Addr0(addr0), .WData0(wdata0), .Ack0(ack0), .RData0(rdata0),
    .Req1(req1), .We1(we1), .Addr1(addr1), .WData1(wdata1), .Ack1(ack1), .RData1(rdata1),
    .MemEn(mem_en), .MemWE(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
    .MemRData(mem_rdata), .Busy(busy), .Owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_b (
    .CLK(clk), .RST(rst),
    .Req0(b_req0), .We0(b_we0), .Addr0(b_addr0), .WData0(b_wdata0), .Ack0(b_ack0), .RData0(b_rdata0),
    .Req1(b_req1), .We1(b_we1), .Addr1(b_addr1), .WData1(b_wdata1), .Ack1(b_ack1), .RData1(b_rdata1),
    .MemEn(b_mem_en), .MemWE(b_mem_we), .MemAddr(b_mem_addr), .MemWData(b_mem_wdata),
    .MemRData(b_mem_rdata), .Busy(b_busy), .Owner(b_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories drive valid data only in the exact latency cycle, garbage otherwise.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic          pre_en;
  logic [7:0]    pre_addr, ra_a, ra_b;
  logic [DW-1:0] pre_data;
  logic [2:0]    vp_a;
  logic          vp_b;

  always @(posedge clk) begin
    if (pre_en) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end else begin
      if (mem_en && mem_we) mem_a[mem_addr[7:0]] <= mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end
    if (mem_en) ra_a <= mem_addr[7:0];
    if (b_mem_en) ra_b <= b_mem_addr[7:0];
    vp_a <= {vp_a[1:0], mem_en && !mem_we};
    vp_b <= b_mem_en && !b_mem_we;
  end

  assign mem_rdata   = vp_a[2] ? mem_a[ra_a] : 32'h0BAD0BAD;
  assign b_mem_rdata = vp_b    ? mem_b[ra_b] : 32'h0BAD0BAD;

  int   memen_a = 0, ack0_a = 0, ack1_a = 0, ovl = 0, b2b = 0;
  logic prev_en_a = 1'b0, prev_en_b = 1'b0;

  always @(posedge clk) begin
    if (mem_en) memen_a <= memen_a + 1;
    if (ack0) ack0_a <= ack0_a + 1;
    if (ack1) ack1_a <= ack1_a + 1;
    if ((ack0 && ack1) || (b_ack0 && b_ack1)) ovl <= ovl + 1;
    if ((mem_en && prev_en_a) || (b_mem_en && prev_en_b)) b2b <= b2b + 1;
    prev_en_a <= mem_en;
    prev_en_b <= b_mem_en;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_ack(input int budget, output int port, output int cyc);
    port = -1;
    cyc  = 0;
    while ((cyc < budget) && (port < 0)) begin
      step(1);
      cyc++;
      if (ack0 && ack1) port = 2;
      else if (ack0)    port = 0;
      else if (ack1)    port = 1;
    end
  endtask

  initial begin
    int port, cyc, em, ea, e1, exp_port;

    rst = 1'b1;
    {req0, req1, we0, we1} = '0;
    {b_req0, b_req1, b_we0, b_we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEADBEEF;
    step(1);
    pre_addr = 8'h40; pre_data = 32'hCAFEF00D;
    step(1);
    pre_addr = 8'h44; pre_data = 32'h55AA55AA;
    step(1);
    pre_en = 1'b0;

    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    rst = 1'b0;
    step(1);

    // Single read through the 3-cycle memory.
    em = memen_a;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    step(1);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    step(3);
    chk("t1_no_early_ack", 32'(ack0), 32'd0);
    step(1);
    chk("t1_ack0", 32'(ack0), 32'd1);
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    step(1);
    chk("t1_ack_one_cycle", 32'(ack0), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_one_strobe", 32'(memen_a - em), 32'd1);

    // Debug-port write followed by a core read of the same word.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
    step(1);
    chk("t3_mem_we", 32'(mem_we), 32'd1);
    chk("t3_mem_wdata", mem_wdata, 32'h12345678);
    chk("t3_owner", 32'(owner), 32'd1);
    step(1);
    chk("t3_ack1", 32'(ack1), 32'd1);
    chk("t3_rdata0_kept", rdata0, 32'hDEADBEEF);
    chk("t3_rdata1_kept", rdata1, 32'd0);
    req1 = 1'b0; we1 = 1'b0;
    step(1);
    req0 = 1'b1; addr0 = 32'h20;
    wait_ack(12, port, cyc);
    chk("t3_read_port", 32'(port), 32'd0);
    chk("t3_read_lat", 32'(cyc), 32'd5);
    chk("t3_rdata0", rdata0, 32'h12345678);
    chk("t3_rdata1_untouched", rdata1, 32'd0);
    req0 = 1'b0;
    step(1);

    // Both ports requesting continuously right after reset.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    e1 = ack1_a;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h00000A0A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h34; wdata1 = 32'h00000B0B;
    for (int g = 0; g < 4; g++) begin
`ifdef FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = g % 2;
`endif
      wait_ack(10, port, cyc);
      chk("t2_grant", 32'(port), 32'(exp_port));
      chk("t2_gap", 32'(cyc), (g == 0) ? 32'd2 : 32'd3);
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    step(2);
`ifdef FIXED_PRIO_EN
    chk("t2_ack1_count", 32'(ack1_a - e1), 32'd0);
`else
    chk("t2_ack1_count", 32'(ack1_a - e1), 32'd2);
`endif

    // Reset while a read waits on memory.
    req0 = 1'b1; addr0 = 32'h10;
    step(2);
    chk("t4_wait_busy", 32'(busy), 32'd1);
    em = memen_a;
    ea = ack0_a;
    rst = 1'b1; req0 = 1'b0;
    step(1);
    rst = 1'b0;
    chk("t4_busy_cleared", 32'(busy), 32'd0);
    chk("t4_rdata0_cleared", rdata0, 32'd0);
    step(4);
    chk("t4_no_strobe", 32'(memen_a - em), 32'd0);
    chk("t4_no_ack", 32'(ack0_a - ea), 32'd0);
    req0 = 1'b1;
    wait_ack(12, port, cyc);
    chk("t4_retry_port", 32'(port), 32'd0);
    chk("t4_retry_lat", 32'(cyc), 32'd5);
    chk("t4_retry_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    step(1);

    // Core drops its request while waiting on the read.
    ea = ack0_a;
    req0 = 1'b1; addr0 = 32'h20;
    step(2);
    req0 = 1'b0;
    step(3);
    chk("t6_ack0", 32'(ack0), 32'd1);
    chk("t6_rdata0", rdata0, 32'h12345678);
    step(1);
    chk("t6_idle", 32'(busy), 32'd0);
    step(3);
    chk("t6_one_ack", 32'(ack0_a - ea), 32'd1);

    // Debug request arriving during a core read, 1-cycle memory.
    b_req0 = 1'b1; b_addr0 = 32'h40;
    step(1);
    chk("t5_issue0", 32'(b_mem_en), 32'd1);
    b_req1 = 1'b1; b_addr1 = 32'h44;
    step(2);
    chk("t5_ack0", 32'(b_ack0), 32'd1);
    chk("t5_ack1_low", 32'(b_ack1), 32'd0);
    chk("t5_rdata0", b_rdata0, 32'hCAFEF00D);
    b_req0 = 1'b0;
    step(2);
    chk("t5_issue1", 32'(b_mem_en), 32'd1);
    chk("t5_owner1", 32'(b_owner), 32'd1);
    chk("t5_addr1", b_mem_addr, 32'h44);
    step(2);
    chk("t5_ack1", 32'(b_ack1), 32'd1);
    chk("t5_rdata1", b_rdata1, 32'h55AA55AA);
    chk("t5_rdata0_kept", b_rdata0, 32'hCAFEF00D);
    b_req1 = 1'b0;
    step(2);

    chk("ack_overlap", 32'(ovl), 32'd0);
    chk("mem_en_back_to_back", 32'(b2b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
